// File: rtl/vga_plot_scheduler_pkg.sv
// Shared screen geometry, colour constants and state encoding for the VGA plot scheduler.
// Everything that touches vga_adapter coordinates imports this package.
package vga_plot_scheduler_pkg;

    localparam int NUM_REQ  = 3;
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int C_W      = 3;

    localparam logic [C_W-1:0] BLACK = 3'b000;
    localparam logic [C_W-1:0] WHITE = 3'b111;
    localparam logic [C_W-1:0] RED   = 3'b100;

    typedef enum logic {
        S_SERVE = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    // True when the pixel lands on the visible screen.
    function automatic logic in_range(input logic [X_W-1:0] px, input logic [Y_W-1:0] py);
        return (px < X_W'(SCREEN_W)) && (py < Y_W'(SCREEN_H));
    endfunction

endpackage

// File: rtl/vga_plot_scheduler_if.sv
// Pixel-producer request bus, clear control and registered vga_adapter write port.
// master = producers/game side, slave = scheduler.
interface vga_plot_scheduler_if
    import vga_plot_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 3
);
    logic [NUM_REQ-1:0]     req;
    logic [X_W*NUM_REQ-1:0] req_x;
    logic [Y_W*NUM_REQ-1:0] req_y;
    logic [C_W*NUM_REQ-1:0] req_colour;
    logic [NUM_REQ-1:0]     gnt;

    logic                   clear_start;
    logic [C_W-1:0]         clear_colour;
    logic                   clear_busy;
    logic                   clear_done;

    logic                   plot;
    logic [X_W-1:0]         x;
    logic [Y_W-1:0]         y;
    logic [C_W-1:0]         colour;

    modport master (
        output req, req_x, req_y, req_colour, clear_start, clear_colour,
        input  gnt, clear_busy, clear_done, plot, x, y, colour
    );

    modport slave (
        input  req, req_x, req_y, req_colour, clear_start, clear_colour,
        output gnt, clear_busy, clear_done, plot, x, y, colour
    );

endinterface

// File: rtl/vga_plot_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first set req after ptr, wrapping at N-1.
// Zero latency; enable=0 forces no grant. The pointer register lives in the caller.
module rr_arbiter #(
    parameter int N     = 3,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             enable,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] cand;
    logic             found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = (ptr == IDX_W'(N - 1)) ? '0 : ptr + 1'b1;
        for (int k = 0; k < N; k++) begin
            if (enable && !found && req[cand]) begin
                gnt[cand] = 1'b1;
                idx       = cand;
                found     = 1'b1;
            end
            cand = (cand == IDX_W'(N - 1)) ? '0 : cand + 1'b1;
        end
    end

endmodule

// File: rtl/vga_plot_scheduler.sv
// Round-robin share of the vga_adapter write port plus a pre-emptive full-screen clear engine.
// One pixel per clk, output latency 1; producers hold req until gnt, and see no gnt during a clear.
module vga_plot_scheduler
    import vga_plot_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic                 clk,
    input  logic                 resetn,
    vga_plot_scheduler_if.slave  bus
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [X_W-1:0]   cx_q, cx_d;
    logic [Y_W-1:0]   cy_q, cy_d;
    logic [C_W-1:0]   clr_colour_q, clr_colour_d;
    logic             plot_q, plot_d;
    logic [X_W-1:0]   x_q, x_d;
    logic [Y_W-1:0]   y_q, y_d;
    logic [C_W-1:0]   colour_q, colour_d;
    logic             clear_busy_q, clear_busy_d;
    logic             clear_done_q, clear_done_d;

    logic               arb_en;
    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic [X_W-1:0]     sel_x;
    logic [Y_W-1:0]     sel_y;
    logic [C_W-1:0]     sel_colour;
    logic               last_clear_px;

    // A pending clear_start wins over every producer in the same cycle.
    assign arb_en = resetn && (state_q == S_SERVE) && !bus.clear_start;

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req    (bus.req),
        .ptr    (ptr_q),
        .enable (arb_en),
        .gnt    (gnt),
        .idx    (gnt_idx)
    );

    always_comb begin
        sel_x      = '0;
        sel_y      = '0;
        sel_colour = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_x      = sel_x      | bus.req_x[X_W*i +: X_W];
                sel_y      = sel_y      | bus.req_y[Y_W*i +: Y_W];
                sel_colour = sel_colour | bus.req_colour[C_W*i +: C_W];
            end
        end
    end

    // The output register holds the final clear pixel for one cycle before returning to serve.
    assign last_clear_px = (x_q == X_W'(SCREEN_W - 1)) && (y_q == Y_W'(SCREEN_H - 1));

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        cx_d         = cx_q;
        cy_d         = cy_q;
        clr_colour_d = clr_colour_q;
        plot_d       = 1'b0;
        x_d          = x_q;
        y_d          = y_q;
        colour_d     = colour_q;
        clear_busy_d = clear_busy_q;
        clear_done_d = 1'b0;

        unique case (state_q)
            S_SERVE: begin
                if (bus.clear_start) begin
                    state_d      = S_CLEAR;
                    clr_colour_d = bus.clear_colour;
                    x_d          = '0;
                    y_d          = '0;
                    colour_d     = bus.clear_colour;
                    plot_d       = 1'b1;
                    cx_d         = X_W'(1);
                    cy_d         = '0;
                    clear_busy_d = 1'b1;
                end else if (|gnt) begin
                    ptr_d = gnt_idx;
                    // Off-screen pixels are consumed but never written.
                    if (in_range(sel_x, sel_y)) begin
                        x_d      = sel_x;
                        y_d      = sel_y;
                        colour_d = sel_colour;
                        plot_d   = 1'b1;
                    end
                end
            end
            S_CLEAR: begin
                if (last_clear_px) begin
                    state_d      = S_SERVE;
                    clear_busy_d = 1'b0;
                    clear_done_d = 1'b1;
                end else begin
                    x_d      = cx_q;
                    y_d      = cy_q;
                    colour_d = clr_colour_q;
                    plot_d   = 1'b1;
                    if (cx_q == X_W'(SCREEN_W - 1)) begin
                        cx_d = '0;
                        cy_d = (cy_q == Y_W'(SCREEN_H - 1)) ? '0 : cy_q + 1'b1;
                    end else begin
                        cx_d = cx_q + 1'b1;
                    end
                end
            end
            default: state_d = S_SERVE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= S_SERVE;
            ptr_q        <= IDX_W'(NUM_REQ - 1);
            cx_q         <= '0;
            cy_q         <= '0;
            clr_colour_q <= '0;
            plot_q       <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            colour_q     <= '0;
            clear_busy_q <= 1'b0;
            clear_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            cx_q         <= cx_d;
            cy_q         <= cy_d;
            clr_colour_q <= clr_colour_d;
            plot_q       <= plot_d;
            x_q          <= x_d;
            y_q          <= y_d;
            colour_q     <= colour_d;
            clear_busy_q <= clear_busy_d;
            clear_done_q <= clear_done_d;
        end
    end

    assign bus.gnt        = gnt;
    assign bus.plot       = plot_q;
    assign bus.x          = x_q;
    assign bus.y          = y_q;
    assign bus.colour     = colour_q;
    assign bus.clear_busy = clear_busy_q;
    assign bus.clear_done = clear_done_q;

endmodule

// File: tb/tb_vga_plot_scheduler.sv
// Bench for vga_plot_scheduler: directed scenarios plus randomized producers against a behavioural model.
module tb_vga_plot_scheduler;
    import vga_plot_scheduler_pkg::*;

    localparam int N   = 3;
    localparam int NPX = SCREEN_W * SCREEN_H;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    vga_plot_scheduler_if #(.NUM_REQ(N)) bus();

    vga_plot_scheduler #(.NUM_REQ(N)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Producer-side stimulus
    bit preq[N];
    int px[N], py[N], pc[N];
    logic [N-1:0] gnt_seen;

    // Behavioural model: clear progress tracked as a linear pixel index
    bit m_valid = 1'b0;
    bit m_clear;
    int m_ptr, m_k, m_clr;
    bit m_plot, m_busy, m_done;
    int m_x, m_y, m_c;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_bus();
        for (int i = 0; i < N; i++) begin
            bus.req[i]                  = preq[i];
            bus.req_x[X_W*i +: X_W]     = X_W'(px[i]);
            bus.req_y[Y_W*i +: Y_W]     = Y_W'(py[i]);
            bus.req_colour[C_W*i +: C_W] = C_W'(pc[i]);
        end
    endtask

    function automatic logic [N-1:0] model_gnt();
        logic [N-1:0] r;
        r = '0;
        if (!resetn || m_clear || bus.clear_start) return r;
        for (int j = 1; j <= N; j++) begin
            int i;
            i = (m_ptr + j) % N;
            if (preq[i]) begin
                r[i] = 1'b1;
                return r;
            end
        end
        return r;
    endfunction

    task automatic model_edge(input logic [N-1:0] eg);
        if (!resetn) begin
            m_valid = 1'b1; m_clear = 1'b0; m_ptr = N - 1; m_k = 0; m_clr = 0;
            m_plot = 1'b0; m_busy = 1'b0; m_done = 1'b0;
            m_x = 0; m_y = 0; m_c = 0;
            return;
        end
        m_done = 1'b0;
        if (!m_clear) begin
            if (bus.clear_start) begin
                m_clear = 1'b1; m_k = 1; m_clr = int'(bus.clear_colour);
                m_x = 0; m_y = 0; m_c = m_clr; m_plot = 1'b1; m_busy = 1'b1;
            end else if (eg != '0) begin
                m_plot = 1'b0;
                for (int i = 0; i < N; i++) begin
                    if (eg[i]) begin
                        m_ptr = i;
                        if (px[i] < SCREEN_W && py[i] < SCREEN_H) begin
                            m_x = px[i]; m_y = py[i]; m_c = pc[i]; m_plot = 1'b1;
                        end
                    end
                end
            end else begin
                m_plot = 1'b0;
            end
        end else if (m_k == NPX) begin
            m_clear = 1'b0; m_busy = 1'b0; m_done = 1'b1; m_plot = 1'b0;
        end else begin
            m_x = m_k % SCREEN_W; m_y = m_k / SCREEN_W; m_c = m_clr;
            m_plot = 1'b1; m_k++;
        end
    endtask

    // One clock: check combinational gnt before the edge, registered outputs after it.
    task automatic cycle();
        logic [N-1:0] eg;
        drive_bus();
        #1;
        eg = model_gnt();
        chk("gnt", int'(bus.gnt), int'(eg));
        gnt_seen = bus.gnt;
        @(posedge clk);
        model_edge(eg);
        #1;
        if (m_valid) begin
            chk("plot", int'(bus.plot), int'(m_plot));
            chk("clear_busy", int'(bus.clear_busy), int'(m_busy));
            chk("clear_done", int'(bus.clear_done), int'(m_done));
            if (m_plot) begin
                chk("x", int'(bus.x), m_x);
                chk("y", int'(bus.y), m_y);
                chk("colour", int'(bus.colour), m_c);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seq_gnt[4];
        int seq_idx[4];
        int gcnt, pcnt, busy_cycles, gnt_in_busy, dones;
        bit done_seen;

        seq_gnt = '{1, 2, 4, 1};
        seq_idx = '{0, 1, 2, 0};
        bus.clear_start  = 1'b0;
        bus.clear_colour = BLACK;
        for (int i = 0; i < N; i++) begin
            preq[i] = 1'b0; px[i] = 0; py[i] = 0; pc[i] = 0;
        end
        gnt_seen = '0;

        // Reset
        resetn = 1'b0;
        cycle();
        cycle();
        chk("rst_plot", int'(bus.plot), 0);
        chk("rst_x", int'(bus.x), 0);
        chk("rst_y", int'(bus.y), 0);
        chk("rst_colour", int'(bus.colour), 0);
        chk("rst_busy", int'(bus.clear_busy), 0);
        chk("rst_done", int'(bus.clear_done), 0);

        // 1: all three requesting, round-robin starting at req[0]
        resetn = 1'b1;
        for (int i = 0; i < N; i++) begin
            preq[i] = 1'b1; px[i] = 10 * i + 1; py[i] = i + 2; pc[i] = i + 1;
        end
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("t1_gnt", int'(gnt_seen), seq_gnt[k]);
            chk("t1_plot", int'(bus.plot), 1);
            chk("t1_x", int'(bus.x), 10 * seq_idx[k] + 1);
        end
        for (int i = 0; i < N; i++) preq[i] = 1'b0;
        cycle();

        // 2: only req[1] for 5 cycles
        preq[1] = 1'b1; px[1] = 10; py[1] = 20; pc[1] = int'(WHITE);
        gcnt = 0; pcnt = 0;
        for (int c = 0; c < 7; c++) begin
            if (c == 5) preq[1] = 1'b0;
            cycle();
            gcnt += int'(gnt_seen[1]);
            pcnt += int'(bus.plot);
            if (c == 0) chk("t2_first_plot", int'(bus.plot), 1);
        end
        chk("t2_gnt_count", gcnt, 5);
        chk("t2_plot_count", pcnt, 5);

        // 4: off-screen pixels are granted but not plotted
        preq[2] = 1'b1; px[2] = 160; py[2] = 5; pc[2] = int'(RED);
        cycle();
        chk("t4_gnt_x", int'(gnt_seen), 4);
        chk("t4_plot_x", int'(bus.plot), 0);
        px[2] = 3; py[2] = 120;
        cycle();
        chk("t4_gnt_y", int'(gnt_seen), 4);
        chk("t4_plot_y", int'(bus.plot), 0);
        preq[2] = 1'b0;
        cycle();

        // 3 + 6: clear_start together with req[0]
        preq[0] = 1'b1; px[0] = 1; py[0] = 2; pc[0] = int'(RED);
        bus.clear_start = 1'b1; bus.clear_colour = BLACK;
        cycle();
        chk("t3_start_gnt", int'(gnt_seen), 0);
        chk("t3_first_x", int'(bus.x), 0);
        chk("t3_first_y", int'(bus.y), 0);
        chk("t3_first_busy", int'(bus.clear_busy), 1);
        busy_cycles = 1; gnt_in_busy = 0; done_seen = 1'b0;
        for (int c = 0; c < NPX + 100 && !done_seen; c++) begin
            if (c == 1000) begin
                bus.clear_start = 1'b1; bus.clear_colour = WHITE;
            end else begin
                bus.clear_start = 1'b0;
            end
            cycle();
            if (gnt_seen != '0) gnt_in_busy++;
            if (bus.clear_busy) begin
                busy_cycles++;
                if (busy_cycles == 161) begin
                    chk("t3_px161_x", int'(bus.x), 0);
                    chk("t3_px161_y", int'(bus.y), 1);
                    chk("t3_px161_c", int'(bus.colour), int'(BLACK));
                end
                if (busy_cycles == NPX) begin
                    chk("t3_last_x", int'(bus.x), 159);
                    chk("t3_last_y", int'(bus.y), 119);
                end
            end
            if (bus.clear_done) done_seen = 1'b1;
        end
        chk("t3_busy_cycles", busy_cycles, 19200);
        chk("t3_gnt_in_busy", gnt_in_busy, 0);
        chk("t3_done_seen", int'(done_seen), 1);
        chk("t3_done_plot", int'(bus.plot), 0);
        cycle();
        chk("t3_gnt_after", int'(gnt_seen), 1);
        chk("t3_req0_x", int'(bus.x), 1);
        chk("t3_req0_y", int'(bus.y), 2);
        preq[0] = 1'b0;
        cycle();

        // 5: reset in the middle of a clear
        bus.clear_start = 1'b1; bus.clear_colour = RED;
        cycle();
        bus.clear_start = 1'b0;
        for (int c = 0; c < 499; c++) cycle();
        chk("t5_px500_x", int'(bus.x), 19);
        chk("t5_px500_y", int'(bus.y), 3);
        resetn = 1'b0;
        cycle();
        chk("t5_rst_plot", int'(bus.plot), 0);
        chk("t5_rst_busy", int'(bus.clear_busy), 0);
        resetn = 1'b1;
        preq[1] = 1'b1; px[1] = 7; py[1] = 8; pc[1] = 5;
        dones = 0;
        cycle();
        chk("t5_serve_gnt", int'(gnt_seen), 2);
        dones += int'(bus.clear_done);
        for (int c = 0; c < 30; c++) begin
            cycle();
            dones += int'(bus.clear_done);
        end
        chk("t5_no_done", dones, 0);
        preq[1] = 1'b0;

        // Randomized producers honouring the hold-until-grant handshake
        gnt_seen = '0;
        for (int c = 0; c < 3000; c++) begin
            resetn = ($urandom_range(0, 499) != 0);
            for (int i = 0; i < N; i++) begin
                if (!preq[i] || gnt_seen[i] || !resetn) begin
                    preq[i] = ($urandom_range(0, 3) != 0);
                    px[i]   = int'($urandom_range(0, 170));
                    py[i]   = int'($urandom_range(0, 125));
                    pc[i]   = int'($urandom_range(0, 7));
                end
            end
            cycle();
        end
        resetn = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
